// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection: load-use bubbles plus a busy tracker for the
// multi-cycle mult/div unit that owns Hi/Lo, with a saturating stall counter.
module hazard_stall_unit #(
  parameter int MD_LATENCY = 32,
  parameter int COUNT_W    = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   ID_Rs,
  input  logic [4:0]   ID_Rt,
  input  logic         ID_UsesRt,
  input  logic         ID_StartMD,
  input  logic         ID_ReadHiLo,
  input  logic         EX_MemRead,
  input  logic [4:0]   EX_Rt,
  output logic         Stall,
  output logic         PCWrite,
  output logic         IFIDWrite,
  output logic         MDIssue,
  output logic         HiLoBusy,
  output logic [15:0]  StallCount
);

  localparam logic [COUNT_W-1:0] MD_LOAD = COUNT_W'(MD_LATENCY);

  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;
  logic               load_use;
  logic               md_stall;
  logic               rs_hit, rt_hit;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  always_comb begin
    rs_hit   = (EX_Rt == ID_Rs);
    rt_hit   = ID_UsesRt && (EX_Rt == ID_Rt);
    load_use = EX_MemRead && (EX_Rt != 5'd0) && (rs_hit || rt_hit);
  end

  // A second mult/div is structural; mfhi/mflo is a data hazard on Hi/Lo.
  always_comb begin
    HiLoBusy  = (cnt_q != '0);
    md_stall  = HiLoBusy && (ID_ReadHiLo || ID_StartMD);
    Stall     = load_use || md_stall;
    PCWrite   = ~Stall;
    IFIDWrite = ~Stall;
    MDIssue   = ID_StartMD && ~Stall;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (MDIssue)
      cnt_d = MD_LOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed vector table, randomized run against a
// cycle-indexed reference model, and a StallCount saturation run.
module tb_hazard_stall_unit;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UsesRt, ID_StartMD, ID_ReadHiLo, EX_MemRead;
  logic        Stall, PCWrite, IFIDWrite, MDIssue, HiLoBusy;
  logic [15:0] StallCount;

  int total = 0;
  int bad   = 0;

  hazard_stall_unit #(.MD_LATENCY(LAT), .COUNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_StartMD(ID_StartMD), .ID_ReadHiLo(ID_ReadHiLo),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .Stall(Stall), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .MDIssue(MDIssue), .HiLoBusy(HiLoBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt, ex_rt;
    logic       uses_rt, start, rdhl, memrd;
    logic       e_stall, e_issue, e_busy;
    int         e_scnt;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(logic r, int rs, int rt, logic u, logic st, logic rd,
                              logic mr, int ert, logic es, logic ei, logic eb, int sc);
    vec_t v;
    v.rst = r; v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = u; v.start = st;
    v.rdhl = rd; v.memrd = mr; v.ex_rt = 5'(ert);
    v.e_stall = es; v.e_issue = ei; v.e_busy = eb; v.e_scnt = sc;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic [4:0] rs, logic [4:0] rt, logic u, logic st,
                       logic rd, logic mr, logic [4:0] ert);
    rst = r; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = u; ID_StartMD = st;
    ID_ReadHiLo = rd; EX_MemRead = mr; EX_Rt = ert;
  endtask

  // Reference model: busy tracked as the last cycle index covered by an issue.
  longint cyc;
  longint busy_end;
  int     m_scnt;

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_stall", int'(Stall), 0);
    chk("reset_pcwrite", int'(PCWrite), 1);
    chk("reset_busy", int'(HiLoBusy), 0);
    chk("reset_scnt", int'(StallCount), 0);

    //            rst rs rt u st rd mr ert  stall iss busy scnt
    tbl[0]  = mk(0, 8, 0, 0, 0, 0, 1, 8,  1, 0, 0, 0);   // load-use on rs
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1);   // load to r0
    tbl[3]  = mk(0, 3, 8, 0, 0, 0, 1, 8,  0, 0, 0, 1);   // rt not a source
    tbl[4]  = mk(0, 3, 8, 1, 0, 0, 1, 8,  1, 0, 0, 1);   // rt is a source
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 2);   // mult issues
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 2);   // mfhi stalls x4
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 3);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 4);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 5);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 6);   // mfhi proceeds
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 6);   // back-to-back mult
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 6);
    tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 7);
    tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 8);
    tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 9);   // cnt==1 still stalls
    tbl[16] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 10);  // second issues
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 10);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 10);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 10);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 10);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 10);
    tbl[22] = mk(0, 5, 0, 0, 1, 0, 1, 5,  1, 0, 0, 10);  // LU + mult: no issue
    tbl[23] = mk(0, 5, 0, 0, 1, 0, 0, 5,  0, 1, 0, 11);  // reissue
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 11);
    tbl[25] = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 11);  // reset with cnt==3
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[27] = mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0);   // mfhi unprotected
    tbl[28] = mk(1, 9, 0, 0, 0, 0, 1, 9,  1, 0, 0, 0);   // outputs live in reset
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].start,
            tbl[i].rdhl, tbl[i].memrd, tbl[i].ex_rt);
      #1;
      chk($sformatf("vec%0d_stall", i), int'(Stall), int'(tbl[i].e_stall));
      chk($sformatf("vec%0d_ifidwrite", i), int'(IFIDWrite), int'(!tbl[i].e_stall));
      chk($sformatf("vec%0d_issue", i), int'(MDIssue), int'(tbl[i].e_issue));
      chk($sformatf("vec%0d_busy", i), int'(HiLoBusy), int'(tbl[i].e_busy));
      chk($sformatf("vec%0d_scnt", i), int'(StallCount), tbl[i].e_scnt);
    end

    // Randomized run; start from a clean reset so the model is in sync.
    @(negedge clk);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    cyc = 0; busy_end = -1; m_scnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, u, st, rd, mr, lu, bsy, es, ei;
      logic [4:0] rs, rt, ert;
      @(negedge clk);
      r   = ($urandom_range(0, 99) == 0);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      ert = 5'($urandom_range(0, 3));
      u   = 1'($urandom);
      mr  = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 4) == 0);
      rd  = ($urandom_range(0, 3) == 0);
      drive(r, rs, rt, u, st, rd, mr, ert);
      lu  = mr && (ert != 0) && (ert == rs || (u && ert == rt));
      bsy = (cyc <= busy_end);
      es  = lu || (bsy && (st || rd));
      ei  = st && !es;
      #1;
      chk("rnd_stall", int'(Stall), int'(es));
      chk("rnd_pcwrite", int'(PCWrite), int'(!es));
      chk("rnd_issue", int'(MDIssue), int'(ei));
      chk("rnd_busy", int'(HiLoBusy), int'(bsy));
      chk("rnd_scnt", int'(StallCount), m_scnt);
      @(posedge clk);
      if (r) begin
        busy_end = -1; m_scnt = 0;
      end else begin
        if (ei) busy_end = cyc + LAT;
        if (es && m_scnt < 65535) m_scnt++;
      end
      cyc++;
    end

    // Saturation: hold a load-use hazard long past 65535 stalled cycles.
    @(negedge clk);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1'b0, 5'd1, 0, 0, 0, 0, 1'b1, 5'd1);
    for (int n = 0; n < 65534; n++) @(negedge clk);
    #1;
    chk("sat_below", int'(StallCount), 65534);
    for (int n = 0; n < 4466; n++) @(negedge clk);
    #1;
    chk("sat_stall", int'(Stall), 1);
    chk("sat_scnt", int'(StallCount), 65535);
    @(negedge clk);
    #1;
    chk("sat_hold", int'(StallCount), 65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
